// File: rtl/csr_wr_arb_pkg.sv
// Shared types and constants for the CSR write-port arbiter.
package csr_wr_arb_pkg;

  localparam int unsigned DataWDef = 64;
  localparam int unsigned AddrWDef = 12;

  // CSR addresses written by the trap sequencer.
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMstatus = 12'h300;

  // Arbiter state: whether a deferred EX write is being held.
  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_PEND  = 1'b1
  } arb_state_e;

  // Source driven into the output stage this cycle.
  typedef enum logic [1:0] {
    SelNone = 2'd0,
    SelTrap = 2'd1,
    SelPend = 2'd2,
    SelEx   = 2'd3
  } arb_sel_e;

endpackage

// File: rtl/csr_wr_arb_if.sv
// Bus bundle between clint/EX, the arbiter and csr_reg.
interface csr_wr_arb_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 12
);
  logic              trap_we_i;
  logic [ADDR_W-1:0] trap_addr_i;
  logic [DATA_W-1:0] trap_data_i;
  logic              ex_req_i;
  logic [ADDR_W-1:0] ex_addr_i;
  logic [DATA_W-1:0] ex_data_i;
  logic              ex_kill_i;
  logic              ex_gnt_o;
  logic              hold_o;
  logic              csr_we_o;
  logic [ADDR_W-1:0] csr_waddr_o;
  logic [DATA_W-1:0] csr_wdata_o;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] csr_rdata_i;
  logic [DATA_W-1:0] rd_data_o;

  // Arbiter side.
  modport slave (
    input  trap_we_i, trap_addr_i, trap_data_i,
    input  ex_req_i, ex_addr_i, ex_data_i, ex_kill_i,
    input  rd_addr_i, csr_rdata_i,
    output ex_gnt_o, hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, rd_data_o
  );

  // Requester / environment side.
  modport master (
    output trap_we_i, trap_addr_i, trap_data_i,
    output ex_req_i, ex_addr_i, ex_data_i, ex_kill_i,
    output rd_addr_i, csr_rdata_i,
    input  ex_gnt_o, hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, rd_data_o
  );
endinterface

// File: rtl/csr_wr_arb_pend_buf.sv
// One-entry holding register for a deferred EX CSR write.
module csr_pend_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_i,
  input  logic              drop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              pend_v_o,
  output logic [ADDR_W-1:0] pend_addr_o,
  output logic [DATA_W-1:0] pend_data_o
);

  logic              pend_v_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;

  // Capture wins over drop: draining the old entry and loading a new one share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else if (capture_i) begin
      pend_v_q    <= 1'b1;
      pend_addr_q <= addr_i;
      pend_data_q <= data_i;
    end else if (drop_i) begin
      pend_v_q    <= 1'b0;
    end
  end

  assign pend_v_o    = pend_v_q;
  assign pend_addr_o = pend_addr_q;
  assign pend_data_o = pend_data_q;

endmodule

// File: rtl/csr_wr_arb.sv
// Arbitrates the csr_reg write port between the trap sequencer and EX CSR writes.
module csr_wr_arb
  import csr_wr_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned ADDR_W = AddrWDef
) (
  input logic           clk,
  input logic           rst_n,
  csr_wr_arb_if.slave   bus
);

  arb_state_e        state_q, state_d;
  arb_sel_e          sel;
  logic              ex_v;
  logic              gnt;
  logic              pend_capture;
  logic              pend_drop;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              csr_we_q;
  logic [ADDR_W-1:0] csr_waddr_q;
  logic [DATA_W-1:0] csr_wdata_q;

  assign ex_v = bus.ex_req_i & ~bus.ex_kill_i;

  csr_pend_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_pend_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture_i   (pend_capture),
    .drop_i      (pend_drop),
    .addr_i      (bus.ex_addr_i),
    .data_i      (bus.ex_data_i),
    .pend_v_o    (pend_v),
    .pend_addr_o (pend_addr),
    .pend_data_o (pend_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Next state, source selection and grant; trap > pending > new EX.
  always_comb begin
    state_d      = state_q;
    sel          = SelNone;
    gnt          = 1'b0;
    pend_capture = 1'b0;
    pend_drop    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (bus.trap_we_i) begin
          sel = SelTrap;
          if (ex_v) begin
            gnt          = 1'b1;
            pend_capture = 1'b1;
            state_d      = S_PEND;
          end
        end else if (ex_v) begin
          sel = SelEx;
          gnt = 1'b1;
        end
      end
      S_PEND: begin
        if (bus.trap_we_i) begin
          sel = SelTrap;
          // Trap write is architecturally later and overwrites the same CSR.
          if (bus.trap_addr_i == pend_addr) begin
            pend_drop = 1'b1;
            state_d   = S_EMPTY;
          end
        end else begin
          sel = SelPend;
          if (ex_v) begin
            gnt          = 1'b1;
            pend_capture = 1'b1;
          end else begin
            pend_drop = 1'b1;
            state_d   = S_EMPTY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Write source mux.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    case (sel)
      SelTrap: begin
        sel_addr = bus.trap_addr_i;
        sel_data = bus.trap_data_i;
      end
      SelPend: begin
        sel_addr = pend_addr;
        sel_data = pend_data;
      end
      SelEx: begin
        sel_addr = bus.ex_addr_i;
        sel_data = bus.ex_data_i;
      end
      default: ;
    endcase
  end

  // Output stage: one cycle from selection to csr_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_we_q    <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
    end else begin
      csr_we_q <= (sel != SelNone);
      if (sel != SelNone) begin
        csr_waddr_q <= sel_addr;
        csr_wdata_q <= sel_data;
      end
    end
  end

  // Combinational outputs, forced low while reset is held.
  always_comb begin
    bus.ex_gnt_o = gnt & rst_n;
    bus.hold_o   = (state_q == S_PEND) & bus.trap_we_i & bus.ex_req_i & rst_n;
    if (pend_v && (pend_addr == bus.rd_addr_i)) begin
      bus.rd_data_o = pend_data;
    end else if (csr_we_q && (csr_waddr_q == bus.rd_addr_i)) begin
      bus.rd_data_o = csr_wdata_q;
    end else begin
      bus.rd_data_o = bus.csr_rdata_i;
    end
  end

  assign bus.csr_we_o    = csr_we_q;
  assign bus.csr_waddr_o = csr_waddr_q;
  assign bus.csr_wdata_o = csr_wdata_q;

endmodule

// File: tb/tb_csr_wr_arb.sv
// Directed vector bench for csr_wr_arb.
module tb_csr_wr_arb;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  csr_wr_arb_if #(.DATA_W(64), .ADDR_W(12)) bus ();

  csr_wr_arb #(.DATA_W(64), .ADDR_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tw;
    logic [11:0] ta;
    logic [63:0] td;
    logic        er;
    logic [11:0] ea;
    logic [63:0] ed;
    logic        kill;
    logic [11:0] ra;
    logic [63:0] rdat;
    logic        gnt;
    logic        hold;
    logic        we;
    logic [11:0] wa;
    logic [63:0] wd;
    logic [63:0] rd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic tw, input logic [11:0] ta, input logic [63:0] td,
                              input logic er, input logic [11:0] ea, input logic [63:0] ed,
                              input logic kill, input logic [11:0] ra, input logic [63:0] rdat,
                              input logic gnt, input logic hold, input logic we,
                              input logic [11:0] wa, input logic [63:0] wd,
                              input logic [63:0] rd);
    vec_t v;
    v.tw = tw; v.ta = ta; v.td = td; v.er = er; v.ea = ea; v.ed = ed; v.kill = kill;
    v.ra = ra; v.rdat = rdat; v.gnt = gnt; v.hold = hold; v.we = we; v.wa = wa; v.wd = wd;
    v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic tw, input logic [11:0] ta, input logic [63:0] td,
                       input logic er, input logic [11:0] ea, input logic [63:0] ed,
                       input logic kill, input logic [11:0] ra, input logic [63:0] rdat);
    bus.trap_we_i   = tw;
    bus.trap_addr_i = ta;
    bus.trap_data_i = td;
    bus.ex_req_i    = er;
    bus.ex_addr_i   = ea;
    bus.ex_data_i   = ed;
    bus.ex_kill_i   = kill;
    bus.rd_addr_i   = ra;
    bus.csr_rdata_i = rdat;
  endtask

  localparam logic [11:0] RaNone = 12'hfff;
  localparam logic [63:0] RdDef  = 64'h1234;

  initial begin
    checks = 0;
    errors = 0;

    // Columns: trap(we,addr,data) ex(req,addr,data,kill) rd(addr,rdata) |
    //          exp gnt hold we waddr wdata rd_data (waddr/wdata checked only when we=1)
    // Idle EX write
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, RaNone, RdDef, 0, 0, 0, 0, 0, RdDef));
    vq.push_back(mk(0, 0, 0, 1, 12'h305, 64'h8000_0000, 0, RaNone, RdDef,
                    1, 0, 0, 0, 0, RdDef));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, RaNone, RdDef, 0, 0, 1, 12'h305, 64'h8000_0000, RdDef));
    // Collision
    vq.push_back(mk(1, 12'h341, 64'h8000_0100, 1, 12'h340, 64'hAA, 0, RaNone, RdDef,
                    1, 0, 0, 0, 0, RdDef));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, RaNone, RdDef, 0, 0, 1, 12'h341, 64'h8000_0100, RdDef));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, RaNone, RdDef, 0, 0, 1, 12'h340, 64'hAA, RdDef));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, RaNone, RdDef, 0, 0, 0, 0, 0, RdDef));
    // Stall during trap burst
    vq.push_back(mk(1, 12'h341, 64'h100, 1, 12'h340, 64'h11, 0, RaNone, RdDef,
                    1, 0, 0, 0, 0, RdDef));
    vq.push_back(mk(1, 12'h342, 64'h2, 1, 12'h305, 64'h22, 0, RaNone, RdDef,
                    0, 1, 1, 12'h341, 64'h100, RdDef));
    vq.push_back(mk(1, 12'h300, 64'h1800, 1, 12'h305, 64'h22, 0, RaNone, RdDef,
                    0, 1, 1, 12'h342, 64'h2, RdDef));
    vq.push_back(mk(0, 0, 0, 1, 12'h305, 64'h22, 0, RaNone, RdDef,
                    1, 0, 1, 12'h300, 64'h1800, RdDef));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, RaNone, RdDef, 0, 0, 1, 12'h340, 64'h11, RdDef));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, RaNone, RdDef, 0, 0, 1, 12'h305, 64'h22, RdDef));
    // Supersede
    vq.push_back(mk(1, 12'h341, 64'h5, 1, 12'h300, 64'h1888, 0, RaNone, RdDef,
                    1, 0, 0, 0, 0, RdDef));
    vq.push_back(mk(1, 12'h300, 64'h80, 0, 0, 0, 0, RaNone, RdDef, 0, 0, 1, 12'h341, 64'h5, RdDef));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, RaNone, RdDef, 0, 0, 1, 12'h300, 64'h80, RdDef));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 12'h300, RdDef, 0, 0, 0, 0, 0, RdDef));
    // Kill
    vq.push_back(mk(0, 0, 0, 1, 12'h305, 64'h33, 1, RaNone, RdDef, 0, 0, 0, 0, 0, RdDef));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, RaNone, RdDef, 0, 0, 0, 0, 0, RdDef));
    // Forwarding; kill while pending must not cancel the entry
    vq.push_back(mk(1, 12'h341, 64'h7, 1, 12'h340, 64'h55, 0, 12'h340, 64'h11,
                    1, 0, 0, 0, 0, 64'h11));
    vq.push_back(mk(1, 12'h342, 64'h8, 1, 12'h305, 64'h66, 1, 12'h340, 64'h11,
                    0, 1, 1, 12'h341, 64'h7, 64'h55));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 12'h342, 64'h11, 0, 0, 1, 12'h342, 64'h8, 64'h8));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 12'h340, 64'h11, 0, 0, 1, 12'h340, 64'h55, 64'h55));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, RaNone, RdDef, 0, 0, 0, 0, 0, RdDef));

    // Reset values, with requests active during reset
    rst_n = 1'b0;
    drive(1, 12'h341, 64'h1, 1, 12'h340, 64'h2, 0, RaNone, RdDef);
    #3;
    chk("rst gnt", 64'(bus.ex_gnt_o), 64'd0);
    chk("rst hold", 64'(bus.hold_o), 64'd0);
    chk("rst we", 64'(bus.csr_we_o), 64'd0);
    chk("rst waddr", 64'(bus.csr_waddr_o), 64'd0);
    chk("rst wdata", bus.csr_wdata_o, 64'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, RaNone, RdDef);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].tw, vq[i].ta, vq[i].td, vq[i].er, vq[i].ea, vq[i].ed, vq[i].kill,
            vq[i].ra, vq[i].rdat);
      #2;
      chk($sformatf("v%0d gnt", i), 64'(bus.ex_gnt_o), 64'(vq[i].gnt));
      chk($sformatf("v%0d hold", i), 64'(bus.hold_o), 64'(vq[i].hold));
      chk($sformatf("v%0d we", i), 64'(bus.csr_we_o), 64'(vq[i].we));
      if (vq[i].we) begin
        chk($sformatf("v%0d waddr", i), 64'(bus.csr_waddr_o), 64'(vq[i].wa));
        chk($sformatf("v%0d wdata", i), bus.csr_wdata_o, vq[i].wd);
      end
      chk($sformatf("v%0d rd_data", i), bus.rd_data_o, vq[i].rd);
    end

    // Async reset while a deferred write is held mid-burst
    @(negedge clk);
    drive(1, 12'h341, 64'h1, 1, 12'h340, 64'h99, 0, 12'h340, 64'h77);
    @(negedge clk);
    drive(1, 12'h342, 64'h2, 1, 12'h305, 64'h98, 0, 12'h340, 64'h77);
    #2;
    chk("pre-rst hold", 64'(bus.hold_o), 64'd1);
    chk("pre-rst fwd", bus.rd_data_o, 64'h99);
    #1 rst_n = 1'b0;
    #1;
    chk("mid-rst gnt", 64'(bus.ex_gnt_o), 64'd0);
    chk("mid-rst hold", 64'(bus.hold_o), 64'd0);
    chk("mid-rst we", 64'(bus.csr_we_o), 64'd0);
    chk("mid-rst waddr", 64'(bus.csr_waddr_o), 64'd0);
    chk("mid-rst wdata", bus.csr_wdata_o, 64'd0);
    chk("mid-rst fwd", bus.rd_data_o, 64'h77);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 12'h340, 64'h77);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      chk($sformatf("post-rst%0d we", c), 64'(bus.csr_we_o), 64'd0);
      chk($sformatf("post-rst%0d fwd", c), bus.rd_data_o, 64'h77);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
